// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, ALU-operation and FSM encodings for the ALU issue controller.
package alu_ctrl_pkg;

    localparam logic [2:0] OPC_AND = 3'b000;
    localparam logic [2:0] OPC_OR  = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;
    localparam logic [2:0] OPC_NOR = 3'b100;
    localparam logic [2:0] OPC_SLT = 3'b101;

    localparam logic [1:0] ALUOP_AND = 2'b00;
    localparam logic [1:0] ALUOP_OR  = 2'b01;
    localparam logic [1:0] ALUOP_ADD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } ctrlState_e;

    typedef struct packed {
        logic       aInv;
        logic       bInv;
        logic       cin;
        logic [1:0] op;
        logic       legal;
    } aluCtrl_s;

    // SUB and SLT share the a + ~b + 1 datapath; NOR is AND of both inverted operands.
    function automatic aluCtrl_s decodeOp(input logic [2:0] opc);
        aluCtrl_s c;
        c = '{aInv: 1'b0, bInv: 1'b0, cin: 1'b0, op: ALUOP_AND, legal: 1'b1};
        case (opc)
            OPC_AND: c.op = ALUOP_AND;
            OPC_OR:  c.op = ALUOP_OR;
            OPC_ADD: c.op = ALUOP_ADD;
            OPC_SUB, OPC_SLT: begin
                c.bInv = 1'b1;
                c.cin  = 1'b1;
                c.op   = ALUOP_ADD;
            end
            OPC_NOR: begin
                c.aInv = 1'b1;
                c.bInv = 1'b1;
                c.op   = ALUOP_AND;
            end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Upstream request and downstream result handshakes of the ALU issue controller.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// the sender holds valid and payload stable until then, and valid does not depend on ready.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int OPC_W  = 3
);
    logic              inValid;
    logic              inReady;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] srcA;
    logic [DATA_W-1:0] srcB;

    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outData;
    logic              zeroFlag;
    logic              carryFlag;
    logic              overflowFlag;
    logic              illegalOp;

    modport master (
        output inValid, opcode, srcA, srcB, outReady,
        input  inReady, outValid, outData, zeroFlag, carryFlag, overflowFlag, illegalOp
    );

    modport slave (
        input  inValid, opcode, srcA, srcB, outReady,
        output inReady, outValid, outData, zeroFlag, carryFlag, overflowFlag, illegalOp
    );
endinterface

// File: rtl/alu_issue_ctrl_flag_gen.sv
// Combinational result/flag shaping from the raw ALU output for the latched opcode.
// Signed overflow reporting is enabled by defining OVF_FLAG_EN.
module alu_flag_gen
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] res,
    input  logic              carryOut,
    input  logic              effASign,
    input  logic              effBSign,
    input  logic [2:0]        opcode,
    output logic [DATA_W-1:0] outData,
    output logic              zero,
    output logic              carry,
    output logic              overflow
);
`ifdef OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic isArith;
    logic isLegal;
    logic ovfRaw;
    logic sltBit;

    always_comb begin
        isArith = (opcode == OPC_ADD) || (opcode == OPC_SUB) || (opcode == OPC_SLT);
        isLegal = (opcode <= OPC_SLT);
        ovfRaw  = OVF_EN && isArith && (effASign == effBSign) && (res[DATA_W-1] != effASign);
        // Without overflow detection the sign of a - b alone decides SLT.
        sltBit  = res[DATA_W-1] ^ ovfRaw;
        outData = '0;
        if (opcode == OPC_SLT) begin
            outData = {{(DATA_W-1){1'b0}}, sltBit};
        end else if (isLegal) begin
            outData = res;
        end
        carry    = isArith && carryOut;
        overflow = ovfRaw;
        zero     = isLegal && (outData == '0);
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencer that issues one opcode to the external 64-bit ALU and returns a registered result with flags.
// Define OVF_FLAG_EN to enable signed overflow reporting and overflow-corrected SLT.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int OPC_W  = 3
) (
    input  logic                clk,
    input  logic                rstN,
    alu_issue_ctrl_if.slave     bus,
    output logic [DATA_W-1:0]   aluA,
    output logic [DATA_W-1:0]   aluB,
    output logic                aluAInvert,
    output logic                aluBInvert,
    output logic                aluCarryIn,
    output logic [1:0]          aluOperation,
    input  logic [DATA_W:0]     aluResult,
    input  logic                aluCarryOut,
    output ctrlState_e          dbgState
);
    ctrlState_e        state;
    ctrlState_e        stateNext;
    logic              acceptEn;
    logic              captureEn;
    aluCtrl_s          decoded;
    logic [OPC_W-1:0]  opReg;
    logic [DATA_W-1:0] fgData;
    logic              fgZero;
    logic              fgCarry;
    logic              fgOverflow;
    logic              unusedResMsb;

    assign unusedResMsb = aluResult[DATA_W];
    assign decoded      = decodeOp(bus.opcode);
    assign dbgState     = state;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= ST_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext    = state;
        acceptEn     = 1'b0;
        captureEn    = 1'b0;
        bus.inReady  = 1'b0;
        bus.outValid = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.inReady = 1'b1;
                if (bus.inValid) begin
                    acceptEn  = 1'b1;
                    stateNext = ST_EXEC;
                end
            end
            ST_EXEC: begin
                captureEn = 1'b1;
                stateNext = ST_DONE;
            end
            ST_DONE: begin
                bus.outValid = 1'b1;
                if (bus.outReady) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    alu_flag_gen #(.DATA_W(DATA_W)) flagGen (
        .res      (aluResult[DATA_W-1:0]),
        .carryOut (aluCarryOut),
        .effASign (aluA[DATA_W-1] ^ aluAInvert),
        .effBSign (aluB[DATA_W-1] ^ aluBInvert),
        .opcode   (opReg),
        .outData  (fgData),
        .zero     (fgZero),
        .carry    (fgCarry),
        .overflow (fgOverflow)
    );

    // ALU drive lines only change on a legal accept; an illegal opcode leaves the ALU untouched.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            opReg            <= '0;
            aluA             <= '0;
            aluB             <= '0;
            aluAInvert       <= 1'b0;
            aluBInvert       <= 1'b0;
            aluCarryIn       <= 1'b0;
            aluOperation     <= ALUOP_AND;
            bus.outData      <= '0;
            bus.zeroFlag     <= 1'b0;
            bus.carryFlag    <= 1'b0;
            bus.overflowFlag <= 1'b0;
            bus.illegalOp    <= 1'b0;
        end else begin
            if (acceptEn) begin
                opReg <= bus.opcode;
                if (decoded.legal) begin
                    aluA         <= bus.srcA;
                    aluB         <= bus.srcB;
                    aluAInvert   <= decoded.aInv;
                    aluBInvert   <= decoded.bInv;
                    aluCarryIn   <= decoded.cin;
                    aluOperation <= decoded.op;
                end
            end
            if (captureEn) begin
                bus.outData      <= fgData;
                bus.zeroFlag     <= fgZero;
                bus.carryFlag    <= fgCarry;
                bus.overflowFlag <= fgOverflow;
                bus.illegalOp    <= (opReg > OPC_SLT);
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, transaction-level reference model and directed vectors.
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;

`ifdef OVF_FLAG_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic        clk  = 1'b0;
    logic        rstN = 1'b0;
    logic [63:0] aluA, aluB;
    logic        aluAInvert, aluBInvert, aluCarryIn;
    logic [1:0]  aluOperation;
    logic [64:0] aluResult;
    logic        aluCarryOut;
    ctrlState_e  dbgState;

    int nChecks = 0;
    int nFail   = 0;

    alu_issue_ctrl_if #(.DATA_W(64), .OPC_W(3)) bus ();

    alu_issue_ctrl #(.DATA_W(64), .OPC_W(3)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .bus          (bus),
        .aluA         (aluA),
        .aluB         (aluB),
        .aluAInvert   (aluAInvert),
        .aluBInvert   (aluBInvert),
        .aluCarryIn   (aluCarryIn),
        .aluOperation (aluOperation),
        .aluResult    (aluResult),
        .aluCarryOut  (aluCarryOut),
        .dbgState     (dbgState)
    );

    always #5 clk = ~clk;

    // Stand-in for ALU64Bit; bit 64 of the result is deliberately junk.
    logic [63:0] effA, effB, aluLogic;
    logic [64:0] aluSum;
    always_comb begin
        effA   = aluAInvert ? ~aluA : aluA;
        effB   = aluBInvert ? ~aluB : aluB;
        aluSum = {1'b0, effA} + {1'b0, effB} + {64'd0, aluCarryIn};
        case (aluOperation)
            2'b00:   aluLogic = effA & effB;
            2'b01:   aluLogic = effA | effB;
            default: aluLogic = aluSum[63:0];
        endcase
        aluCarryOut = (aluOperation == 2'b10) ? aluSum[64] : 1'b0;
        aluResult   = {~aluCarryOut, aluLogic};
    end

    // Expected result word: {illegal, overflow, carry, zero, data}.
    function automatic logic [67:0] modelOp(input logic [2:0] opc, input logic [63:0] a, input logic [63:0] b);
        logic [64:0] wide;
        logic [63:0] data;
        logic        c, v, ill, z;
        wide = '0; data = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (opc)
            3'd0: data = a & b;
            3'd1: data = a | b;
            3'd2: begin
                wide = {1'b0, a} + {1'b0, b};
                data = wide[63:0]; c = wide[64];
                v = (a[63] == b[63]) && (data[63] != a[63]);
            end
            3'd3, 3'd5: begin
                wide = {1'b0, a} + {1'b0, ~b} + 65'd1;
                data = wide[63:0]; c = wide[64];
                v = (a[63] != b[63]) && (data[63] != a[63]);
                if (opc == 3'd5) begin
                    if (OVF) data = {63'd0, ($signed(a) < $signed(b))};
                    else     data = {63'd0, wide[63]};
                end
            end
            3'd4: data = ~(a | b);
            default: ill = 1'b1;
        endcase
        if (!OVF) v = 1'b0;
        z = !ill && (data == 64'd0);
        return {ill, v, c, z, data};
    endfunction

    function automatic logic [4:0] ctrlFor(input logic [2:0] opc);
        case (opc)
            3'd0:       return 5'b000_00;
            3'd1:       return 5'b000_01;
            3'd2:       return 5'b000_10;
            3'd3, 3'd5: return 5'b011_10;
            default:    return 5'b110_00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted op yields exactly one result, visible from the second cycle after acceptance.
    logic [67:0] exp_q[$];
    bit          mBusy = 1'b0;
    int          mAge  = 0;
    logic [4:0]  mCtrl = '0;
    logic [63:0] mA = '0, mB = '0;

    always @(posedge clk) begin
        if (!rstN) begin
            mBusy = 1'b0; mAge = 0; exp_q.delete();
            mCtrl = '0; mA = '0; mB = '0;
        end else if (mBusy && mAge >= 1) begin
            if (bus.outReady) begin
                mBusy = 1'b0;
                void'(exp_q.pop_front());
            end
        end else if (mBusy) begin
            mAge++;
        end else if (bus.inValid) begin
            mBusy = 1'b1; mAge = 0;
            exp_q.push_back(modelOp(bus.opcode, bus.srcA, bus.srcB));
            if (bus.opcode <= 3'd5) begin
                mCtrl = ctrlFor(bus.opcode); mA = bus.srcA; mB = bus.srcB;
            end
        end
    end

    always @(negedge clk) begin
        if (rstN) begin
            chk("inReady", {67'd0, bus.inReady}, {67'd0, !mBusy});
            chk("outValid", {67'd0, bus.outValid}, {67'd0, (mBusy && mAge >= 1)});
            if (mBusy && mAge >= 1 && exp_q.size() > 0)
                chk("outWord", {bus.illegalOp, bus.overflowFlag, bus.carryFlag, bus.zeroFlag, bus.outData}, exp_q[0]);
            chk("aluCtrl", {63'd0, aluAInvert, aluBInvert, aluCarryIn, aluOperation}, {63'd0, mCtrl});
            chk("aluA", {4'd0, aluA}, {4'd0, mA});
            chk("aluB", {4'd0, aluB}, {4'd0, mB});
        end
    end

    function automatic logic [67:0] w(input bit ill, input bit v, input bit c, input bit z, input logic [63:0] d);
        return {ill, v, c, z, d};
    endfunction

    // Issue one op, check timing and (optionally) a hand-computed result, hold in DONE, then release.
    task automatic runOp(input logic [2:0] opc, input logic [63:0] a, input logic [63:0] b,
                         input bit useLit, input logic [67:0] lit, input int hold);
        int waitN;
        logic [67:0] first;
        @(negedge clk);
        bus.inValid = 1'b1; bus.opcode = opc; bus.srcA = a; bus.srcB = b;
        waitN = 0;
        while (!bus.inReady && waitN < 20) begin
            @(negedge clk);
            waitN++;
        end
        chk("acceptWait", {67'd0, (waitN < 20)}, 68'd1);
        @(negedge clk);
        bus.inValid = 1'b0;
        chk("execNoValid", {67'd0, bus.outValid}, 68'd0);
        if (opc == 3'd3) chk("subCtrl", {63'd0, aluAInvert, aluBInvert, aluCarryIn, aluOperation}, 68'b011_10);
        @(negedge clk);
        chk("latencyValid", {67'd0, bus.outValid}, 68'd1);
        first = {bus.illegalOp, bus.overflowFlag, bus.carryFlag, bus.zeroFlag, bus.outData};
        if (useLit) chk("litResult", first, lit);
        for (int i = 0; i < hold; i++) begin
            bus.inValid = i[0];
            @(negedge clk);
            chk("holdStable", {bus.illegalOp, bus.overflowFlag, bus.carryFlag, bus.zeroFlag, bus.outData}, first);
            chk("holdInReady", {67'd0, bus.inReady}, 68'd0);
        end
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.outReady = 1'b0;
        chk("releaseIdle", {66'd0, bus.inReady, bus.outValid}, 68'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inValid = 1'b0; bus.opcode = '0; bus.srcA = '0; bus.srcB = '0; bus.outReady = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstInReady", {67'd0, bus.inReady}, 68'd1);
        chk("rstOutValid", {67'd0, bus.outValid}, 68'd0);
        chk("rstOutWord", {bus.illegalOp, bus.overflowFlag, bus.carryFlag, bus.zeroFlag, bus.outData}, 68'd0);
        chk("rstAluOp", {66'd0, aluOperation}, 68'd0);
        rstN = 1'b1;

        runOp(OPC_AND, 64'd5, 64'd2, 1'b1, w(0, 0, 0, 1, 64'd0), 0);
        runOp(OPC_OR,  64'd5, 64'd2, 1'b1, w(0, 0, 0, 0, 64'd7), 0);
        runOp(OPC_ADD, 64'd5, 64'd2, 1'b1, w(0, 0, 0, 0, 64'd7), 0);
        runOp(OPC_SUB, 64'd5, 64'd2, 1'b1, w(0, 0, 1, 0, 64'd3), 0);
        runOp(OPC_NOR, 64'd5, 64'd2, 1'b1, w(0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8), 0);
        runOp(OPC_SLT, 64'd2, 64'd5, 1'b1, w(0, 0, 0, 0, 64'd1), 0);
        runOp(OPC_SLT, 64'd5, 64'd2, 1'b1, w(0, 0, 1, 1, 64'd0), 0);
        runOp(OPC_SLT, 64'h8000_0000_0000_0000, 64'd1, 1'b1, w(0, OVF, 1, !OVF, {63'd0, OVF}), 0);
        runOp(OPC_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, w(0, OVF, 0, 0, 64'h8000_0000_0000_0000), 0);
        // Carry-out with a zero result, held under backpressure with inValid pulses.
        runOp(OPC_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, w(0, 0, 1, 1, 64'd0), 5);
        runOp(3'b110, 64'd9, 64'd9, 1'b1, w(1, 0, 0, 0, 64'd0), 2);
        runOp(OPC_ADD, 64'd1, 64'd1, 1'b1, w(0, 0, 0, 0, 64'd2), 0);
        runOp(3'b111, 64'd0, 64'd0, 1'b1, w(1, 0, 0, 0, 64'd0), 0);

        // Abort during EXEC: no result may ever appear for it.
        @(negedge clk);
        bus.inValid = 1'b1; bus.opcode = OPC_ADD; bus.srcA = 64'd3; bus.srcB = 64'd4;
        @(negedge clk);
        bus.inValid = 1'b0;
        chk("abortInExec", {66'd0, dbgState}, {66'd0, ST_EXEC});
        rstN = 1'b0;
        #1;
        chk("abortOutValid", {67'd0, bus.outValid}, 68'd0);
        chk("abortInReady", {67'd0, bus.inReady}, 68'd1);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abortNoResult", {67'd0, bus.outValid}, 68'd0);
        end
        runOp(OPC_SUB, 64'd10, 64'd3, 1'b1, w(0, 0, 1, 0, 64'd7), 0);

        for (int i = 0; i < 16; i++)
            runOp(3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, '0,
                  $urandom_range(0, 2));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
